// File: rtl/extmem.sv
// extmem: synthesizable external-memory responder on the cache ext* bus.
//
// Serves 4-beat instruction-line reads, 2-beat data reads, 4-beat block
// writes and single-dword byte-masked writes out of a 2**AW x 64-bit
// synchronous-read RAM. Every state and memory update is qualified by phi2.
//
// Optional feature macro: EXTMEM_WAIT_EN
//   defined   -> each read accept spends WAIT beats in WAITS before the
//                first reply beat (WAIT=0 behaves like undefined)
//   undefined -> first reply beat directly follows the accept edge
//
// Handshake: a request is taken on a clk edge where phi2 & extreq & extrdy
// are all 1; the requester holds extreq and its fields until then.
// extreply marks a beat whose extrdata/exterror/extreplyto are meaningful.
//
// Ports:
//   clk, reset, phi2        clock, synchronous active-high reset, beat enable
//   extaddr[31:0]           request byte address
//   extwdata[63:0]          big-endian lane-aligned write data
//   extsz[4:0]              31 = block, 0..7 = single access of extsz+1 bytes
//   extreq, extwr, extsrc   request valid, write flag, requester tag
//   extrdy                  idle and able to accept
//   extreply, extreplyto    reply beat flag, tag latched at accept
//   extrdata[63:0]          reply data (0 on error beats and when idle)
//   exterror                bus error for the current beat
//   dbg_state_o[3:0]        current FSM state encoding
module extmem #(
  parameter int AW   = 12,
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phi2,
  input  logic [31:0] extaddr,
  input  logic [63:0] extwdata,
  input  logic [4:0]  extsz,
  input  logic        extreq,
  input  logic        extwr,
  input  logic        extsrc,
  output logic        extrdy,
  output logic        extreply,
  output logic        extreplyto,
  output logic [63:0] extrdata,
  output logic        exterror,
  output logic [3:0]  dbg_state_o
);

`ifdef EXTMEM_WAIT_EN
  localparam bit WaitEn = (WAIT != 0);
`else
  localparam bit WaitEn = 1'b0;
`endif
  localparam int WCW = 8;

  // WAITS keeps its encoding in both builds so the debug state values
  // do not shift; it is unreachable when the wait feature is off.
  typedef enum logic [3:0] {
    S_IDLE, S_WAITS,
    S_IR0, S_IR1, S_IR2, S_IR3,
    S_DR0, S_DR1,
    S_WB1, S_WB2, S_WB3
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic             blk_q;
  logic             src_q;
  logic             err_q;
  logic             err_pulse_q;
  logic             rdy_q;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [63:0]      rdata_q;
  logic [63:0]      mem [0:(1<<AW)-1];

  logic [AW-1:0]    req_idx;
  logic [2:0]       req_off;
  logic             req_blk;
  logic             req_err;
  logic             accept;
  logic [AW-1:0]    idx_sel;
  logic [AW-1:0]    rd_addr;
  logic             we;
  logic [AW-1:0]    wa;
  logic [7:0]       wmask;
  logic [7:0]       smask;
  logic             busy_beat;

  assign req_idx = extaddr[AW+2:3];
  assign req_off = extaddr[2:0];
  assign req_blk = (extsz == 5'd31);
  // Out-of-range address, or a single access that spills past the dword.
  // Sizes 8..30 are not defined on the bus and are refused as errors.
  assign req_err = (extaddr[31:AW+3] != '0) ||
                   (!req_blk && ((extsz[4:3] != 2'b00) ||
                    (({1'b0, req_off} + {1'b0, extsz[2:0]}) > 4'd7)));

  assign extrdy = rdy_q && (state_q == S_IDLE) && !reset;
  assign accept = phi2 && extreq && extrdy;

  // On the accept edge the index has not been latched yet.
  assign idx_sel = (state_q == S_IDLE) ? req_idx : idx_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (phi2) begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (extwr) begin
              state_d = req_blk ? S_WB1 : S_IDLE;
            end else if (WaitEn) begin
              state_d = S_WAITS;
              wcnt_d  = WCW'(WAIT - 1);
            end else begin
              state_d = req_blk ? S_IR0 : S_DR0;
            end
          end
        end
        S_WAITS: begin
          if (wcnt_q == '0) state_d = blk_q ? S_IR0 : S_DR0;
          else              wcnt_d  = wcnt_q - 1'b1;
        end
        S_IR0:   state_d = S_IR1;
        S_IR1:   state_d = S_IR2;
        S_IR2:   state_d = S_IR3;
        S_IR3:   state_d = S_IDLE;
        S_DR0:   state_d = S_DR1;
        S_DR1:   state_d = S_IDLE;
        S_WB1:   state_d = S_WB2;
        S_WB2:   state_d = S_WB3;
        S_WB3:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // RAM is addressed from the state being entered so the registered read
  // data lines up with the beat that state represents.
  always_comb begin
    rd_addr = idx_sel;
    case (state_d)
      S_IR0:   rd_addr = {idx_sel[AW-1:2], 2'd0};
      S_IR1:   rd_addr = {idx_sel[AW-1:2], 2'd1};
      S_IR2:   rd_addr = {idx_sel[AW-1:2], 2'd2};
      S_IR3:   rd_addr = {idx_sel[AW-1:2], 2'd3};
      S_DR1:   rd_addr = idx_sel ^ AW'(1);
      default: rd_addr = idx_sel;
    endcase
  end

  // Bytes off .. off+size of the addressed dword.
  always_comb begin
    smask = '0;
    for (int b = 0; b < 8; b++) begin
      smask[b] = (4'(b) >= {1'b0, req_off}) &&
                 (4'(b) <= ({1'b0, req_off} + {1'b0, extsz[2:0]}));
    end
  end

  always_comb begin
    we    = 1'b0;
    wa    = idx_q;
    wmask = '0;
    if (accept && extwr && !req_err) begin
      we    = 1'b1;
      wa    = req_blk ? {req_idx[AW-1:2], 2'd0} : req_idx;
      wmask = req_blk ? 8'hFF : smask;
    end else if (phi2 && !err_q) begin
      case (state_q)
        S_WB1: begin we = 1'b1; wa = {idx_q[AW-1:2], 2'd1}; wmask = 8'hFF; end
        S_WB2: begin we = 1'b1; wa = {idx_q[AW-1:2], 2'd2}; wmask = 8'hFF; end
        S_WB3: begin we = 1'b1; wa = {idx_q[AW-1:2], 2'd3}; wmask = 8'hFF; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      blk_q       <= 1'b0;
      src_q       <= 1'b0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      rdy_q       <= 1'b0;
      wcnt_q      <= '0;
    end else if (phi2) begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rdy_q       <= 1'b1;
      // One-beat error flag for a refused single write (FSM stays idle).
      err_pulse_q <= accept && extwr && !req_blk && req_err;
      if (accept) begin
        idx_q <= req_idx;
        blk_q <= req_blk;
        src_q <= extsrc;
        err_q <= req_err;
      end
    end
  end

  // Memory array and its read register; not reset, reset aborts only the FSM.
  always_ff @(posedge clk) begin
    if (phi2 && !reset) begin
      rdata_q <= mem[rd_addr];
      if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (wmask[b]) mem[wa][63-8*b -: 8] <= extwdata[63-8*b -: 8];
        end
      end
    end
  end

  assign extreply   = (state_q == S_IR0) || (state_q == S_IR1) ||
                      (state_q == S_IR2) || (state_q == S_IR3) ||
                      (state_q == S_DR0) || (state_q == S_DR1);
  assign busy_beat  = extreply || (state_q == S_WB1) ||
                      (state_q == S_WB2) || (state_q == S_WB3);
  assign extreplyto = src_q;
  assign extrdata   = (extreply && !err_q) ? rdata_q : '0;
  assign exterror   = err_pulse_q || (err_q && busy_beat);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_extmem.sv
module tb_extmem;

  logic        clk;
  logic        reset;
  logic        phi2;
  logic [31:0] extaddr;
  logic [63:0] extwdata;
  logic [4:0]  extsz;
  logic        extreq;
  logic        extwr;
  logic        extsrc;
  logic        extrdy;
  logic        extreply;
  logic        extreplyto;
  logic [63:0] extrdata;
  logic        exterror;
  logic [3:0]  dbg_state;

  extmem #(.AW(12), .WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .phi2       (phi2),
    .extaddr    (extaddr),
    .extwdata   (extwdata),
    .extsz      (extsz),
    .extreq     (extreq),
    .extwr      (extwr),
    .extsrc     (extsrc),
    .extrdy     (extrdy),
    .extreply   (extreply),
    .extreplyto (extreplyto),
    .extrdata   (extrdata),
    .exterror   (exterror),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset / beat enable ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    phi2 = 1'b0;
    forever begin
      @(negedge clk);
      phi2 = ~phi2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected reply beat: {exterror, extreplyto, extrdata}
  logic [65:0] exp_q[$];
  int checks;
  int errors;
  int n_exp;
  int n_replies;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic err, input logic to, input logic [63:0] d);
    exp_q.push_back({err, to, d});
    n_exp++;
  endtask

  // Monitor: samples each beat just after its opening phi2 edge.
  initial begin
    logic [65:0] e;
    forever begin
      @(posedge clk);
      if (phi2) begin
        #1;
        if (extreply) begin
          n_replies++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_reply: got %h with no reply expected",
                     {exterror, extreplyto, extrdata});
          end else begin
            e = exp_q.pop_front();
            check("reply_beat", {exterror, extreplyto, extrdata}, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to #1 after the next phi2 edge.
  task automatic step();
    @(posedge clk);
    while (phi2 !== 1'b1) @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the accept edge has passed.
  task automatic issue(input logic [31:0] a, input logic [63:0] wd,
                       input logic [4:0] sz, input logic wr, input logic src);
    int n;
    n = 0;
    extaddr = a; extwdata = wd; extsz = sz; extwr = wr; extsrc = src;
    extreq = 1'b1;
    while (!extrdy && n < 50) begin
      step();
      n++;
    end
    if (!extrdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: extrdy=%0b expected 1 within 50 beats", extrdy);
    end else begin
      step();
    end
    extreq = 1'b0;
  endtask

  task automatic bwrite(input logic [31:0] a, input logic [255:0] line, input logic exp_err);
    issue(a, line[255:192], 5'd31, 1'b1, 1'b0);
    for (int k = 1; k < 4; k++) begin
      extwdata = line[255-64*k -: 64];
      check("wb_exterror", {65'd0, exterror}, {65'd0, exp_err});
      step();
    end
  endtask

  task automatic bread(input logic [31:0] a, input logic src);
    issue(a, 64'd0, 5'd31, 1'b0, src);
  endtask

  localparam logic [63:0] A  = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] B  = 64'hB0B1_B2B3_B4B5_B6B7;
  localparam logic [63:0] C  = 64'hC0C1_C2C3_C4C5_C6C7;
  localparam logic [63:0] D  = 64'hD0D1_D2D3_D4D5_D6D7;
  localparam logic [63:0] M8 = 64'h8888_1234_5678_8888;
  localparam logic [63:0] M9 = 64'h9999_0000_1111_9999;
  localparam logic [63:0] MA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] MB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] W0 = 64'h5700_0000_0000_0000;
  localparam logic [63:0] W1 = 64'h5711_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h5722_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h5733_3333_3333_3333;

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int lat_exp;
    checks = 0; errors = 0; n_exp = 0; n_replies = 0;
    reset = 1'b1;
    extaddr = '0; extwdata = '0; extsz = '0; extreq = 1'b0; extwr = 1'b0; extsrc = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {exterror, extreplyto, extrdata}, 66'd0);
    check("reset_reply_rdy", {64'd0, extreply, extrdy}, 66'd0);
    step();
    reset = 1'b0;
    check("rdy_before_first_beat", {65'd0, extrdy}, 66'd0);
    step();
    check("rdy_after_first_beat", {65'd0, extrdy}, 66'd1);

    // 1: line read at 0x10 returns the aligned line 0..3
    bwrite(32'h0, {A, B, C, D}, 1'b0);
    push(1'b0, 1'b0, A); push(1'b0, 1'b0, B); push(1'b0, 1'b0, C); push(1'b0, 1'b0, D);
    bread(32'h10, 1'b0);
    repeat (3) step();
    check("rdy_during_ir3", {65'd0, extrdy}, 66'd0);
    step();
    check("rdy_after_line_read", {65'd0, extrdy}, 66'd1);

    // 2: single read at 0x48 -> mem[9], mem[8]
    bwrite(32'h40, {M8, M9, MA, MB}, 1'b0);
    push(1'b0, 1'b1, M9); push(1'b0, 1'b1, M8);
    issue(32'h48, 64'd0, 5'd7, 1'b0, 1'b1);
    repeat (2) step();

    // 3: byte-masked write, then an overrunning one that must be refused
    issue(32'h40, 64'd0, 5'd7, 1'b1, 1'b0);
    issue(32'h43, 64'hFFFF_FFBE_EFFF_FFFF, 5'd1, 1'b1, 1'b0);
    check("sw_exterror_ok", {65'd0, exterror}, 66'd0);
    check("sw_rdy_stays", {65'd0, extrdy}, 66'd1);
    issue(32'h43, 64'h1122_3344_5566_7788, 5'd5, 1'b1, 1'b0);
    check("sw_overrun_err", {65'd0, exterror}, 66'd1);
    step();
    check("sw_err_one_beat", {65'd0, exterror}, 66'd0);
    push(1'b0, 1'b0, 64'h0000_00BE_EF00_0000); push(1'b0, 1'b0, M9);
    issue(32'h40, 64'd0, 5'd7, 1'b0, 1'b0);
    repeat (2) step();

    // 4: block write at 0x100, line read at 0x108
    bwrite(32'h100, {W0, W1, W2, W3}, 1'b0);
    push(1'b0, 1'b1, W0); push(1'b0, 1'b1, W1); push(1'b0, 1'b1, W2); push(1'b0, 1'b1, W3);
    bread(32'h108, 1'b1);
    repeat (4) step();

    // errored block write raises exterror through WB3
    bwrite(32'h0020_0000, {D, C, B, A}, 1'b1);
    check("wb_err_cleared", {65'd0, exterror}, 66'd0);

    // 5: out-of-range line read, then the same read cut by reset in IR1
    push(1'b1, 1'b0, 64'd0); push(1'b1, 1'b0, 64'd0);
    push(1'b1, 1'b0, 64'd0); push(1'b1, 1'b0, 64'd0);
    bread(32'h0010_0000, 1'b0);
    repeat (4) step();
    push(1'b1, 1'b1, 64'd0); push(1'b1, 1'b1, 64'd0);
    bread(32'h0010_0000, 1'b1);
    step();
    reset = 1'b1;
    step();
    check("midburst_reset_reply", {64'd0, extreply, extrdy}, 66'd0);
    step();
    reset = 1'b0;
    check("rdy_low_after_reset", {65'd0, extrdy}, 66'd0);
    step();
    check("rdy_after_reset_beat", {65'd0, extrdy}, 66'd1);
    repeat (3) step();

    // 6: reply latency of a single read (also re-reads line 0x100 after reset)
`ifdef EXTMEM_WAIT_EN
    lat_exp = 3;
`else
    lat_exp = 1;
`endif
    push(1'b0, 1'b0, W0); push(1'b0, 1'b0, W1);
    issue(32'h100, 64'd0, 5'd7, 1'b0, 1'b0);
    lat = 1;
    while (!extreply && lat < 20) begin
      step();
      lat++;
    end
    check("read_latency", 66'(lat), 66'(lat_exp));
    repeat (6) step();

    check("queue_drained", 66'(exp_q.size()), 66'd0);
    check("reply_count", 66'(n_replies), 66'(n_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
